// File: rtl/byte_to_word16.sv
// Packs pairs of bytes from a valid/ready stream into 16-bit words.
// Each completed word drives out with a one-cycle load pulse for a downstream Register16.
module byte_to_word16 #(
    parameter bit HI_FIRST       = 1'b1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [15:0] out,
    output logic        load,
    output logic        half,
    output logic        timeout
);

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [7:0]     held_reg, held_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [15:0]    out_reg, out_next;
    logic           timeout_reg, timeout_next;
    logic           accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            held_reg    <= '0;
            cnt_reg     <= '0;
            out_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            held_reg    <= held_next;
            cnt_reg     <= cnt_next;
            out_reg     <= out_next;
            timeout_reg <= timeout_next;
        end
    end

    // flush outranks both accept and timeout; out only changes on word completion
    always_comb begin
        state_next   = state_reg;
        held_next    = held_reg;
        cnt_next     = cnt_reg;
        out_next     = out_reg;
        timeout_next = 1'b0;
        accept       = in_valid & in_ready & ~flush;
        case (state_reg)
            IDLE: begin
                if (flush) begin
                    held_next = '0;
                end else if (accept) begin
                    held_next  = in_byte;
                    cnt_next   = '0;
                    state_next = HALF;
                end
            end
            HALF: begin
                if (flush) begin
                    held_next  = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (accept) begin
                    out_next   = HI_FIRST ? {held_reg, in_byte} : {in_byte, held_reg};
                    held_next  = '0;
                    cnt_next   = '0;
                    state_next = EMIT;
                end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
                    held_next    = '0;
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else if (TO_EN) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            EMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready = (state_reg != EMIT);
    assign load     = (state_reg == EMIT);
    assign half     = (state_reg == HALF);
    assign out      = out_reg;
    assign timeout  = timeout_reg;

endmodule

// File: tb/tb_byte_to_word16.sv
// Directed bench for byte_to_word16: three instances (default, low-byte-first,
// short timeout) share one stimulus stream.
module tb_byte_to_word16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;

    logic        rdy_d, load_d, half_d, to_d;
    logic [15:0] out_d;
    logic        rdy_l, load_l, half_l, to_l;
    logic [15:0] out_l;
    logic        rdy_t, load_t, half_t, to_t;
    logic [15:0] out_t;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    byte_to_word16 #(.HI_FIRST(1'b1), .TIMEOUT_CYCLES(16)) u_def (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(rdy_d), .flush(flush), .out(out_d), .load(load_d),
        .half(half_d), .timeout(to_d));

    byte_to_word16 #(.HI_FIRST(1'b0), .TIMEOUT_CYCLES(16)) u_lo (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(rdy_l), .flush(flush), .out(out_l), .load(load_l),
        .half(half_l), .timeout(to_l));

    byte_to_word16 #(.HI_FIRST(1'b1), .TIMEOUT_CYCLES(4)) u_to (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(rdy_t), .flush(flush), .out(out_t), .load(load_t),
        .half(half_t), .timeout(to_t));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s obs=%h exp=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        in_valid = 1'b0;
        flush    = 1'b0;
        // reset state
        cyc();
        chk("rst_out",     out_d,           16'h0000);
        chk("rst_load",    {15'd0, load_d}, 16'd0);
        chk("rst_half",    {15'd0, half_d}, 16'd0);
        chk("rst_ready",   {15'd0, rdy_d},  16'd1);
        chk("rst_timeout", {15'd0, to_d},   16'd0);
        reset = 1'b0;

        // 1: ab, cd -> abcd
        in_valid = 1'b1; in_byte = 8'hab;
        cyc();
        chk("t1_half",  {15'd0, half_d}, 16'd1);
        in_byte = 8'hcd;
        cyc();
        chk("t1_load",  {15'd0, load_d}, 16'd1);
        chk("t1_out",   out_d,           16'habcd);
        chk("t1_ready", {15'd0, rdy_d},  16'd0);
        in_valid = 1'b0;
        cyc();
        chk("t1_load_end", {15'd0, load_d}, 16'd0);
        chk("t1_out_hold", out_d,           16'habcd);

        // 2: streaming ab,cd,12,34 with in_valid held high
        do_reset();
        in_valid = 1'b1; in_byte = 8'hab;
        cyc();
        in_byte = 8'hcd;
        cyc();
        chk("t2_load1",  {15'd0, load_d}, 16'd1);
        chk("t2_out1",   out_d,           16'habcd);
        chk("t2_ready0", {15'd0, rdy_d},  16'd0);
        in_byte = 8'h12;
        cyc();
        chk("t2_idle_load", {15'd0, load_d}, 16'd0);
        chk("t2_idle_half", {15'd0, half_d}, 16'd0);
        cyc();
        chk("t2_half2", {15'd0, half_d}, 16'd1);
        in_byte = 8'h34;
        cyc();
        chk("t2_load2", {15'd0, load_d}, 16'd1);
        chk("t2_out2",  out_d,           16'h1234);
        in_valid = 1'b0;
        cyc();

        // 3: 34,12 -> lo-first packs 1234, hi-first packs 3412
        do_reset();
        in_valid = 1'b1; in_byte = 8'h34;
        cyc();
        in_byte = 8'h12;
        cyc();
        in_valid = 1'b0;
        chk("t3_lo_out",  out_l,           16'h1234);
        chk("t3_lo_load", {15'd0, load_l}, 16'd1);
        chk("t3_hi_out",  out_d,           16'h3412);
        cyc();

        // 4: timeout after 4 idle HALF cycles
        do_reset();
        in_valid = 1'b1; in_byte = 8'hab;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_still_half", {15'd0, half_t}, 16'd1);
            chk("t4_no_timeout", {15'd0, to_t},   16'd0);
        end
        cyc();
        chk("t4_timeout", {15'd0, to_t},   16'd1);
        chk("t4_idle",    {15'd0, half_t}, 16'd0);
        chk("t4_out",     out_t,           16'h0000);
        chk("t4_no_load", {15'd0, load_t}, 16'd0);
        cyc();
        chk("t4_pulse_end", {15'd0, to_t}, 16'd0);
        in_valid = 1'b1; in_byte = 8'h56;
        cyc();
        in_byte = 8'h78;
        cyc();
        in_valid = 1'b0;
        chk("t4_out2", out_t, 16'h5678);
        cyc();

        // 5: flush with cd offered -> cd not consumed
        do_reset();
        in_valid = 1'b1; in_byte = 8'hab;
        cyc();
        flush = 1'b1; in_byte = 8'hcd;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_half",    {15'd0, half_d}, 16'd0);
        chk("t5_load",    {15'd0, load_d}, 16'd0);
        chk("t5_timeout", {15'd0, to_d},   16'd0);
        cyc();
        chk("t5_load2", {15'd0, load_d}, 16'd0);
        chk("t5_out",   out_d,           16'h0000);
        in_valid = 1'b1; in_byte = 8'h01;
        cyc();
        in_byte = 8'h02;
        cyc();
        in_valid = 1'b0;
        chk("t5_out2", out_d, 16'h0102);
        cyc();

        // 6: asynchronous reset mid-word
        in_valid = 1'b1; in_byte = 8'hab;
        cyc();
        in_valid = 1'b0;
        chk("t6_half_before", {15'd0, half_d}, 16'd1);
        #3 reset = 1'b1;
        #1;
        chk("t6_async_out",  out_d,           16'h0000);
        chk("t6_async_half", {15'd0, half_d}, 16'd0);
        cyc();
        reset = 1'b0;
        chk("t6_no_load", {15'd0, load_d}, 16'd0);
        in_valid = 1'b1; in_byte = 8'hef;
        cyc();
        in_byte = 8'h01;
        cyc();
        in_valid = 1'b0;
        chk("t6_out", out_d, 16'hef01);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
